// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: write-only I2C register slave that collects NBYTES payload
// bytes per frame into data_out (first byte in the MSBs).
// Defining I2C_SLAVE_READ_EN adds read support: data_out is shifted back
// out MSB first, and the byte index wraps after NBYTES bytes.
module i2c_reg_slave #(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned NBYTES      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i2c_sclk,
  inout  wire                   i2c_sdat,
  output logic [8*NBYTES-1:0]   data_out,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int unsigned W = 8 * NBYTES;

`ifdef I2C_SLAVE_READ_EN
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE, TX, TX_ACK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;
`endif

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q, scl_s, sda_s;
  logic start, stop, scl_rise, scl_fall;

  state_t       state, state_nxt;
  logic [3:0]   bit_cnt, bit_cnt_nxt;
  logic [2:0]   byte_cnt, byte_cnt_nxt;
  logic [7:0]   shift, shift_nxt;
  logic [W-1:0] payload, payload_nxt;
  logic [W-1:0] data_out_nxt;
  logic         data_valid_nxt, busy_nxt;
  logic         sda_low, sda_low_nxt;
`ifdef I2C_SLAVE_READ_EN
  logic         rd, rd_nxt;
  logic         mack, mack_nxt;
  logic [7:0]   tx_sr, tx_sr_nxt;
  logic [2:0]   tx_idx;
  logic [W-1:0] tx_word;
`endif

  // Open-drain data line: only ever pulled low or released.
  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

  // Synchronise SCL/SDA and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sdat};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      payload    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      sda_low    <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rd         <= 1'b0;
      mack       <= 1'b0;
      tx_sr      <= '0;
`endif
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      shift      <= shift_nxt;
      payload    <= payload_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      busy       <= busy_nxt;
      sda_low    <= sda_low_nxt;
`ifdef I2C_SLAVE_READ_EN
      rd         <= rd_nxt;
      mack       <= mack_nxt;
      tx_sr      <= tx_sr_nxt;
`endif
    end
  end

  // Next-state and output decode; STOP wins over a simultaneous START.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    byte_cnt_nxt   = byte_cnt;
    shift_nxt      = shift;
    payload_nxt    = payload;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    busy_nxt       = busy;
    sda_low_nxt    = sda_low;
`ifdef I2C_SLAVE_READ_EN
    rd_nxt         = rd;
    mack_nxt       = mack;
    tx_sr_nxt      = tx_sr;
    tx_idx         = byte_cnt;
    tx_word        = '0;
`endif
    if (stop) begin
      state_nxt   = IDLE;
      sda_low_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start) begin
      state_nxt    = ADDR;
      bit_cnt_nxt  = '0;
      byte_cnt_nxt = '0;
      sda_low_nxt  = 1'b0;
      busy_nxt     = 1'b1;
`ifdef I2C_SLAVE_READ_EN
      rd_nxt       = 1'b0;
`endif
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_nxt   = {shift[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            if (shift[7:1] == DEV_ADDR && !shift[0]) begin
              state_nxt   = ADDR_ACK;
              sda_low_nxt = 1'b1;
`ifdef I2C_SLAVE_READ_EN
            end else if (shift[7:1] == DEV_ADDR) begin
              state_nxt   = ADDR_ACK;
              sda_low_nxt = 1'b1;
              rd_nxt      = 1'b1;
`endif
            end else begin
              state_nxt   = IGNORE;
              sda_low_nxt = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_low_nxt = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = DATA;
`ifdef I2C_SLAVE_READ_EN
            if (rd) begin
              tx_word     = data_out << {tx_idx, 3'b000};
              tx_sr_nxt   = tx_word[W-1 -: 8];
              sda_low_nxt = ~tx_word[W-1];
              state_nxt   = TX;
            end
`endif
          end
        end
        DATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_nxt   = {shift[6:0], sda_s};
            payload_nxt = {payload[W-2:0], sda_s};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            if (byte_cnt < 3'(NBYTES)) begin
              state_nxt   = DATA_ACK;
              sda_low_nxt = 1'b1;
            end else begin
              state_nxt   = IGNORE;
              sda_low_nxt = 1'b0;
            end
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_low_nxt  = 1'b0;
            state_nxt    = DATA;
            byte_cnt_nxt = byte_cnt + 3'd1;
            if (byte_cnt == 3'(NBYTES - 1)) begin
              data_out_nxt   = payload;
              data_valid_nxt = 1'b1;
            end
          end
        end
`ifdef I2C_SLAVE_READ_EN
        TX: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low_nxt = 1'b0;
              state_nxt   = TX_ACK;
            end else begin
              tx_sr_nxt   = {tx_sr[6:0], 1'b0};
              sda_low_nxt = ~tx_sr[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            mack_nxt = ~sda_s;
          end else if (scl_fall) begin
            if (mack) begin
              tx_idx       = (byte_cnt == 3'(NBYTES - 1)) ? 3'd0 : byte_cnt + 3'd1;
              byte_cnt_nxt = tx_idx;
              tx_word      = data_out << {tx_idx, 3'b000};
              tx_sr_nxt    = tx_word[W-1 -: 8];
              sda_low_nxt  = ~tx_word[W-1];
              bit_cnt_nxt  = '0;
              state_nxt    = TX;
            end else begin
              sda_low_nxt = 1'b0;
              state_nxt   = IGNORE;
            end
          end
        end
`endif
        IDLE, IGNORE: begin
          sda_low_nxt = 1'b0;
        end
        default: begin
          state_nxt   = IDLE;
          sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed testbench for i2c_reg_slave: bit-banged I2C master with
// hand-computed expectations checked by immediate assertions.
module tb_i2c_reg_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda_bus;
  logic [23:0] data_out;
  logic        data_valid;
  logic        busy;

  int n_assert = 0;
  int n_fail = 0;
  int dv_cnt = 0;
  int slave_low_cnt = 0;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_reg_slave #(.DEV_ADDR(7'h1A), .NBYTES(3), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i2c_sclk   (scl),
    .i2c_sdat   (sda_bus),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count data_valid pulses.
  always @(posedge clk) if (data_valid) dv_cnt <= dv_cnt + 1;

  // Count cycles where the slave pulls SDA low while the master is released.
  always @(negedge clk) if (!m_low && sda_bus === 1'b0) slave_low_cnt <= slave_low_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; q();
    scl = 1'b1;   q();
    m_low = 1'b1; q();
    scl = 1'b0;   q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; q();
    scl = 1'b1;   q();
    m_low = 1'b0; q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; q();
      scl = 1'b1;    q(); q();
      scl = 1'b0;    q();
    end
  endtask

  task automatic ack_phase(output logic ack);
    m_low = 1'b0; q();
    scl = 1'b1;   q();
    ack = (sda_bus === 1'b0);
    q();
    scl = 1'b0;   q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    ack_phase(ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    m_low = 1'b0;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      q();
      scl = 1'b1; q();
      b = {b[6:0], (sda_bus !== 1'b0)};
      q();
      scl = 1'b0;
    end
    q();
    m_low = master_ack; q();
    scl = 1'b1;         q(); q();
    scl = 1'b0;         q();
    m_low = 1'b0;
  endtask

  task automatic write_frame(input logic [23:0] v);
    logic a;
    i2c_start();
    write_byte(8'h34, a); check("frame_addr_ack", 32'(a), 32'd1);
    write_byte(v[23:16], a); check("frame_b1_ack", 32'(a), 32'd1);
    write_byte(v[15:8], a);  check("frame_b2_ack", 32'(a), 32'd1);
    write_byte(v[7:0], a);   check("frame_b3_ack", 32'(a), 32'd1);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         dv_base;
    int         low_base;

    // Reset values
    repeat (5) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sda_released", 32'(sda_bus), 32'h1);
    reset_n = 1'b1;
    q();

    // Basic write frame
    i2c_start();
    check("t1_busy_after_start", 32'(busy), 32'h1);
    write_byte(8'h34, ack); check("t1_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h12, ack); check("t1_b1_ack", 32'(ack), 32'd1);
    write_byte(8'h34, ack); check("t1_b2_ack", 32'(ack), 32'd1);
    write_byte(8'h56, ack); check("t1_b3_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("t1_data_out", 32'(data_out), 32'h123456);
    check("t1_dv_count", 32'(dv_cnt), 32'd1);
    check("t1_busy_after_stop", 32'(busy), 32'h0);

    // Wrong address: slave stays off the bus
    low_base = slave_low_cnt;
    i2c_start();
    write_byte(8'h36, ack); check("t2_addr_nack", 32'(ack), 32'd0);
    write_byte(8'hDE, ack);
    write_byte(8'hAD, ack);
    write_byte(8'hBE, ack);
    check("t2_busy_mid", 32'(busy), 32'h1);
    i2c_stop();
    check("t2_slave_never_low", 32'(slave_low_cnt - low_base), 32'd0);
    check("t2_data_out", 32'(data_out), 32'h123456);
    check("t2_busy_after_stop", 32'(busy), 32'h0);
    check("t2_dv_count", 32'(dv_cnt), 32'd1);

    // Short frame discarded, then full frame
    dv_base = dv_cnt;
    i2c_start();
    write_byte(8'h34, ack); check("t3_addr_ack", 32'(ack), 32'd1);
    write_byte(8'hAA, ack); check("t3_b1_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("t3_no_pulse", 32'(dv_cnt - dv_base), 32'd0);
    check("t3_data_out_kept", 32'(data_out), 32'h123456);
    write_frame(24'h010203);
    check("t3_data_out", 32'(data_out), 32'h010203);
    check("t3_one_pulse", 32'(dv_cnt - dv_base), 32'd1);

    // Extra byte beyond NBYTES is NACKed
    i2c_start();
    write_byte(8'h34, ack); check("t4_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h11, ack); check("t4_b1_ack", 32'(ack), 32'd1);
    write_byte(8'h22, ack); check("t4_b2_ack", 32'(ack), 32'd1);
    write_byte(8'h33, ack); check("t4_b3_ack", 32'(ack), 32'd1);
    write_byte(8'h44, ack); check("t4_b4_nack", 32'(ack), 32'd0);
    check("t4_data_out", 32'(data_out), 32'h112233);
    i2c_stop();

    // Reset during the ACK of data byte 2
    i2c_start();
    write_byte(8'h34, ack); check("t5_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h77, ack); check("t5_b1_ack", 32'(ack), 32'd1);
    send_bits(8'h88);
    m_low = 1'b0; q();
    check("t5_ack_driven", 32'(sda_bus), 32'h0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t5_sda_released", 32'(sda_bus), 32'h1);
    check("t5_data_out_zero", 32'(data_out), 32'h0);
    check("t5_busy_zero", 32'(busy), 32'h0);
    check("t5_dv_zero", 32'(data_valid), 32'h0);
    reset_n = 1'b1;
    q();
    i2c_stop();
    dv_base = dv_cnt;
    write_frame(24'hABCDEF);
    check("t5_data_out", 32'(data_out), 32'hABCDEF);
    check("t5_one_pulse", 32'(dv_cnt - dv_base), 32'd1);

`ifdef I2C_SLAVE_READ_EN
    // Read back a written payload
    write_frame(24'hA5C33C);
    i2c_start();
    write_byte(8'h35, ack); check("t6_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, rb); check("t6_rd_b1", 32'(rb), 32'hA5);
    read_byte(1'b1, rb); check("t6_rd_b2", 32'(rb), 32'hC3);
    read_byte(1'b0, rb); check("t6_rd_b3", 32'(rb), 32'h3C);
    i2c_stop();
    check("t6_busy_after_stop", 32'(busy), 32'h0);
`else
    // Read request is refused when read support is absent
    i2c_start();
    write_byte(8'h35, ack); check("t6_read_nack", 32'(ack), 32'd0);
    read_byte(1'b0, rb);    check("t6_bus_released", 32'(rb), 32'hFF);
    i2c_stop();
    check("t6_data_out_kept", 32'(data_out), 32'hABCDEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
